// File: rtl/Vermitypes_pkg.sv
// Shared Vermibus types: FSM state, request record and latency limit.
package Vermitypes_pkg;

   localparam int MEMORY_MAX_LATENCY = 15;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  strobe_t;
   typedef logic [3:0]  count_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } mem_state_t;

   typedef struct packed {
      word_t   address;
      strobe_t wstrobe;
      word_t   wdata;
   } mem_req_t;

endpackage

// File: rtl/vermi_memory_if.sv
// Vermibus request/response bundle between a master and a memory slave.
interface vermi_memory_if;
   import Vermitypes_pkg::*;

   logic    valid;
   logic    ready;
   word_t   address;
   strobe_t wstrobe;
   word_t   wdata;
   word_t   rdata;

   modport master (output valid, address, wstrobe, wdata, input ready, rdata);
   modport slave  (input valid, address, wstrobe, wdata, output ready, rdata);
endinterface

// File: rtl/vermi_memory_array.sv
// SIZE x 32 storage with byte-lane write enables and a combinational read port.
module vermi_memory_array
   import Vermitypes_pkg::*;
#(
   parameter int SIZE = 1024
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [$clog2(SIZE)-1:0] addr,
   input  strobe_t                 wstrobe,
   input  word_t                   wdata,
   output word_t                   rdata
);

   word_t mem [SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrobe[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/vermi_memory.sv
// Vermibus memory slave with LATENCY wait cycles and a registered one-cycle ready.
// Define VERMI_MEMORY_POSTED_WRITE_EN to acknowledge writes early and commit them from a one-entry buffer.
//  state   | meaning
//  IDLE    | no transfer in flight; also the cycle in which the registered ready is visible
//  WAIT    | request captured, counting down LATENCY; dropping valid aborts
//  RESPOND | last internal cycle; write commits / read data latched into the ready register
module vermi_memory
   import Vermitypes_pkg::*;
#(
   parameter int    SIZE         = 1024,
   parameter int    LATENCY      = 0,
   parameter word_t BASE_ADDRESS = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   vermi_memory_if.slave bus
);

   localparam int     AW  = $clog2(SIZE);
   localparam count_t LAT = count_t'(LATENCY);

   mem_state_t    state_q, state_d;
   count_t        cnt_q, cnt_d;
   mem_req_t      req_q, req_d;
   logic          ready_q, ready_d;
   word_t         rdata_q, rdata_d;
   logic          mem_we;
   word_t         mem_rdata;
   logic          accept;
   logic          in_range;
   logic          is_write;
   logic [AW-1:0] word_idx;

   // BASE_ADDRESS is aligned to the memory span, so the range test is a tag compare.
   assign in_range = (req_q.address[31:AW+2] == BASE_ADDRESS[31:AW+2]);
   assign word_idx = req_q.address[AW+1:2];
   assign is_write = |req_q.wstrobe;

   wire unused_addr_lsb = ^req_q.address[1:0];

`ifdef VERMI_MEMORY_POSTED_WRITE_EN
   logic pend_q, pend_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend_q <= 1'b0;
      else       pend_q <= pend_d;
   end
`else
   logic pend_q;
   assign pend_q = 1'b0;
`endif

   // The cycle showing ready still has the finished request's valid high; never recapture it.
   assign accept = bus.valid && !ready_q && !pend_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      ready_d = 1'b0;
      rdata_d = '0;
      mem_we  = 1'b0;
`ifdef VERMI_MEMORY_POSTED_WRITE_EN
      pend_d  = pend_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               req_d   = '{address: bus.address, wstrobe: bus.wstrobe, wdata: bus.wdata};
               cnt_d   = LAT;
               state_d = (LAT != '0) ? WAIT : RESPOND;
`ifdef VERMI_MEMORY_POSTED_WRITE_EN
               if (bus.wstrobe != 4'h0 && LAT != '0) begin
                  pend_d  = 1'b1;
                  state_d = RESPOND;
               end
`endif
            end
         end
         WAIT: begin
            if (!bus.valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = (cnt_q != '0) ? cnt_q - count_t'(1) : '0;
               if (cnt_q <= count_t'(1)) state_d = RESPOND;
            end
         end
         RESPOND: begin
            state_d = IDLE;
            ready_d = 1'b1;
            if (!is_write && in_range)            rdata_d = mem_rdata;
            if (is_write && in_range && !pend_q)  mem_we  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
`ifdef VERMI_MEMORY_POSTED_WRITE_EN
      // Posted write drains LATENCY cycles after capture; no new capture while pending.
      if (pend_q) begin
         cnt_d = (cnt_q != '0) ? cnt_q - count_t'(1) : '0;
         if (cnt_q <= count_t'(1)) begin
            pend_d = 1'b0;
            mem_we = in_range;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   vermi_memory_array #(.SIZE(SIZE)) u_array (
      .clk     (clk),
      .we      (mem_we),
      .addr    (word_idx),
      .wstrobe (req_q.wstrobe),
      .wdata   (req_q.wdata),
      .rdata   (mem_rdata)
   );

   assign bus.ready = ready_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_vermi_memory.sv
// Bench for vermi_memory: three instances (LATENCY 0, 3, 5) against a behavioural word/lane model.
module tb_vermi_memory;
   import Vermitypes_pkg::*;

   localparam int    SIZE = 1024;
   localparam word_t BASE = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic    v_s [3];
   word_t   a_s [3];
   strobe_t s_s [3];
   word_t   d_s [3];
   logic    r_s [3];
   word_t   q_s [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      vermi_memory_if bus ();
      assign bus.valid   = v_s[g];
      assign bus.address = a_s[g];
      assign bus.wstrobe = s_s[g];
      assign bus.wdata   = d_s[g];
      assign r_s[g]      = bus.ready;
      assign q_s[g]      = bus.rdata;
      vermi_memory #(
         .SIZE         (SIZE),
         .LATENCY      ((g == 0) ? 0 : (g == 1) ? 3 : 5),
         .BASE_ADDRESS (BASE)
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus.slave)
      );
   end

   int errors = 0;
   int checks = 0;

   word_t mem_m [3][SIZE];

   function automatic int lat_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 5;
   endfunction

   function automatic bit in_rng(input word_t a);
      longint off;
      off = longint'({32'h0, a}) - longint'({32'h0, BASE});
      return (off >= 0) && (off < 4 * SIZE);
   endfunction

   function automatic int idx_of(input word_t a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic word_t model_read(input int k, input word_t a);
      return in_rng(a) ? mem_m[k][idx_of(a)] : 32'h0;
   endfunction

   task automatic model_apply(input int k, input word_t a, input strobe_t strb, input word_t wd);
      word_t w;
      if (strb != 4'h0 && in_rng(a)) begin
         w = mem_m[k][idx_of(a)];
         for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wd[8*i +: 8];
         mem_m[k][idx_of(a)] = w;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One complete transfer; measures edges from raising valid to seeing ready.
   task automatic xfer(input int k, input word_t addr, input strobe_t strb, input word_t wd,
                       output word_t got);
      int n;
      int want;
      bit seen;
      bit idle_ok;
      want = lat_of(k) + 2;
`ifdef VERMI_MEMORY_POSTED_WRITE_EN
      if (strb != 4'h0 && lat_of(k) > 0) want = 2;
`endif
      @(posedge clk); #1;
      v_s[k] = 1'b1; a_s[k] = addr; s_s[k] = strb; d_s[k] = wd;
      n = 0; seen = 1'b0; idle_ok = 1'b1; got = '0;
      while (!seen && n < 64) begin
         @(posedge clk); #1;
         n++;
         if (r_s[k]) begin
            seen = 1'b1;
            got  = q_s[k];
         end else if (q_s[k] != 32'h0) begin
            idle_ok = 1'b0;
         end
      end
      check("ready_seen", 32'(seen), 32'd1);
`ifdef VERMI_MEMORY_POSTED_WRITE_EN
      if (strb == 4'h0) check("read_latency_min", 32'(n >= want), 32'd1);
      else              check("write_latency", 32'(n), 32'(want));
`else
      check("latency", 32'(n), 32'(want));
`endif
      check("rdata_zero_while_waiting", 32'(idle_ok), 32'd1);
      @(posedge clk); #1;
      check("ready_single_cycle", 32'(r_s[k]), 32'd0);
      check("rdata_zero_after_ready", q_s[k], 32'h0);
      v_s[k] = 1'b0; s_s[k] = 4'h0;
      model_apply(k, addr, strb, wd);
   endtask

   typedef struct {
      int      k;
      word_t   addr;
      strobe_t strb;
      word_t   wdata;
      word_t   exp;
   } vec_t;

   vec_t vec [13];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      word_t   got, a, wd, expv;
      strobe_t strb;
      int      pulses;
      bit      dbl, prev, rdy;

      vec[0]  = '{0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
      vec[1]  = '{0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF};
      vec[2]  = '{0, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0};
      vec[3]  = '{0, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0};
      vec[4]  = '{0, 32'h0000_0020, 4'h0, 32'h0,         32'h11BB_33DD};
      vec[5]  = '{0, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0};
      vec[6]  = '{0, 32'h0000_1000, 4'h0, 32'h0,         32'h0};
      vec[7]  = '{0, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vec[8]  = '{0, 32'h0000_0000, 4'h0, 32'h0,         32'h0BAD_F00D};
      vec[9]  = '{0, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 32'h0};
      vec[10] = '{0, 32'h0000_0FFF, 4'h0, 32'h0,         32'h1234_5678};
      vec[11] = '{1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 32'h0};
      vec[12] = '{1, 32'h0000_0042, 4'h0, 32'h0,         32'hCAFE_F00D};

      for (int k = 0; k < 3; k++) begin
         v_s[k] = 1'b0; a_s[k] = '0; s_s[k] = '0; d_s[k] = '0;
      end

      #12;
      for (int k = 0; k < 3; k++) begin
         check("reset_ready", 32'(r_s[k]), 32'd0);
         check("reset_rdata", q_s[k], 32'h0);
      end
      #10 reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         xfer(vec[i].k, vec[i].addr, vec[i].strb, vec[i].wdata, got);
         check($sformatf("vec%0d_rdata", i), got, vec[i].exp);
      end

      // Valid held high: one pulse per 3 cycles, never two in a row.
      @(posedge clk); #1;
      v_s[0] = 1'b1; a_s[0] = 32'h10; s_s[0] = 4'h0;
      pulses = 0; dbl = 1'b0; prev = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         if (r_s[0]) begin
            pulses++;
            if (prev) dbl = 1'b1;
         end
         prev = r_s[0];
      end
      v_s[0] = 1'b0;
      check("back_to_back_pulses", 32'(pulses), 32'd3);
      check("no_double_ready", 32'(dbl), 32'd0);

`ifndef VERMI_MEMORY_POSTED_WRITE_EN
      xfer(1, 32'h200, 4'hF, 32'h55AA_55AA, got);
      @(posedge clk); #1;
      v_s[1] = 1'b1; a_s[1] = 32'h200; s_s[1] = 4'hF; d_s[1] = 32'hFFFF_FFFF;
      @(posedge clk); @(posedge clk); #1;
      v_s[1] = 1'b0; s_s[1] = 4'h0;
      rdy = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (r_s[1]) rdy = 1'b1; end
      check("abort_no_ready", 32'(rdy), 32'd0);
      xfer(1, 32'h200, 4'h0, 32'h0, got);
      check("abort_no_write", got, model_read(1, 32'h200));

      xfer(2, 32'h300, 4'hF, 32'h0102_0304, got);
      @(posedge clk); #1;
      v_s[2] = 1'b1; a_s[2] = 32'h300; s_s[2] = 4'hF; d_s[2] = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("reset_wait_ready", 32'(r_s[2]), 32'd0);
      check("reset_wait_rdata", q_s[2], 32'h0);
      @(posedge clk); @(posedge clk); #1;
      v_s[2] = 1'b0; s_s[2] = 4'h0;
      #2 reset = 1'b0;
      rdy = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (r_s[2]) rdy = 1'b1; end
      check("reset_abort_no_ready", 32'(rdy), 32'd0);
      xfer(2, 32'h300, 4'h0, 32'h0, got);
      check("reset_abort_word_unchanged", got, 32'h0102_0304);
`else
      xfer(1, 32'h400, 4'hF, 32'h1357_9BDF, got);
      check("posted_write_rdata", got, 32'h0);
      xfer(1, 32'h400, 4'h0, 32'h0, got);
      check("posted_read_after_write", got, 32'h1357_9BDF);
`endif

      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 16; w++) begin
            xfer(k, 32'h100 + 32'(4 * w), 4'hF, $urandom, got);
            check("rnd_init_rdata", got, 32'h0);
         end
         for (int i = 0; i < 30; i++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
            strb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wd   = $urandom;
            expv = (strb == 4'h0) ? model_read(k, a) : 32'h0;
            xfer(k, a, strb, wd, got);
            check($sformatf("rnd_k%0d_rdata", k), got, expv);
         end
         for (int w = 0; w < 16; w++) begin
            xfer(k, 32'h100 + 32'(4 * w), 4'h0, 32'h0, got);
            check("rnd_final_word", got, model_read(k, 32'h100 + 32'(4 * w)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vermi_memory.md
VERMI_MEMORY -- requirements
Module: vermi_memory

Interface
REQ-001 SHALL have parameter SIZE, default 1024, memory depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 0, number of wait cycles inserted before the response (0..15).
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000, byte address of word 0, aligned to SIZE*4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid, input, 1, request from the Vermibus master.
REQ-007 SHALL have port ready, output, 1, single-cycle response strobe; a transfer completes in a cycle with valid && ready.
REQ-008 SHALL have port address, input, 32, byte address; bits [1:0] ignored.
REQ-009 SHALL have port wstrobe, input, 4, byte-lane write enables; 4'b0000 means read.
REQ-010 SHALL have port wdata, input, 32, write data, lane i = bits [8i+7:8i].
REQ-011 SHALL have port rdata, output, 32, read data, valid in the ready cycle.

Function
REQ-012 SHALL implement states IDLE, WAIT, RESPOND.
REQ-013 IDLE: on valid, SHALL capture address/wstrobe/wdata, load the wait counter with LATENCY, and go to WAIT if LATENCY>0, else RESPOND.
REQ-014 WAIT: SHALL decrement the counter each cycle and go to RESPOND when it reaches 0 after decrement; if valid drops, SHALL return to IDLE with no write and no ready.
REQ-015 RESPOND: SHALL drive ready=1 for exactly one cycle, then go to IDLE; ready SHALL be registered.
REQ-016 Read latency: valid first sampled high at edge N -> ready high in the cycle after edge N+1+LATENCY.
REQ-017 A new request SHALL NOT be accepted in the cycle following ready (mandatory one IDLE cycle).
REQ-018 Reads SHALL present the word at index (address-BASE_ADDRESS)>>2 on rdata in the RESPOND cycle; rdata SHALL be 0 in all other cycles.
REQ-019 Writes SHALL update only lanes with wstrobe[i]=1, committed at the end of the RESPOND cycle; rdata SHALL be 0 for writes.
REQ-020 Out-of-range address (outside BASE_ADDRESS .. BASE_ADDRESS+SIZE*4-1): SHALL respond normally with rdata=0 and no write.
REQ-021 The wait counter SHALL be 4 bits and never wrap below 0.

Reset
REQ-022 On reset assertion, SHALL go to IDLE immediately, with ready=0, rdata=0, counter=0, captured request cleared; array contents are not cleared.
REQ-023 Reset during WAIT or RESPOND SHALL abort the transfer: no write and no ready after reset deasserts until a new valid.

Configuration
REQ-024 Macro VERMI_MEMORY_POSTED_WRITE_EN defined: writes SHALL be acknowledged in RESPOND one cycle after capture regardless of LATENCY, held in a one-entry buffer, and committed LATENCY cycles after capture.
REQ-025 With the macro defined, a request arriving while the buffer is pending SHALL be held (no capture) until the commit cycle has passed; reads are never posted.
REQ-026 Macro undefined: no buffer; writes follow REQ-016 timing exactly like reads.

Structure
REQ-027 The state enum mem_state_t and constant MEMORY_MAX_LATENCY=15 SHALL live in Vermitypes_pkg; word_t SHALL be used for address/data.
REQ-028 A sub-module vermi_memory_array SHALL contain the SIZE x 32 storage with byte-lane write enables and a combinational read port.

Verification
REQ-029 LATENCY=0: write 32'hDEADBEEF to 0x10 with wstrobe 4'hF, then read 0x10 -> ready one cycle after each valid, rdata=32'hDEADBEEF.
REQ-030 Byte lanes: over word 0x11223344, write wdata 32'hAABBCCDD with wstrobe 4'b0101 -> read returns 32'h11BB33DD.
REQ-031 LATENCY=3: read issued at edge 10 -> ready high only in the cycle after edge 14; ready never high two consecutive cycles.
REQ-032 Out of range, SIZE=1024, BASE 0: read 0x1000 -> ready with rdata=0; write 0x1000 then read 0x0 -> word 0 unchanged.
REQ-033 Reset asserted during WAIT of a write (LATENCY=5) -> ready stays 0, target word unchanged, next read responds normally.
REQ-034 With VERMI_MEMORY_POSTED_WRITE_EN, LATENCY=4: write acknowledged after 1 cycle; immediate read of same address is stalled until commit and returns the new data.
